ahb_protocol_checker: RTL
=========================

# ahb_protocol_checker

Synthesizable, parametrised AHB protocol checker that passively observes one manager/subordinate bus segment and reports rule violations as registered pulses, sticky flags and a saturating counter. Unlike the interface-level burst-stability assertion it replaces, it tracks full burst state (beat count, expected address, wrap boundary, wait states, two-cycle ERROR response). It sits beside the bus in both the VIP harness and silicon debug builds, and has no effect on bus traffic.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, data bus width (8..1024, power of 2); max legal HSIZE = log2(DATA_WIDTH/8)
- CNT_WIDTH, 16, violation counter width
- CHECK_EN, 8'hFF, per-check enable mask (bit i enables check i)
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  ADDR_WIDTH
- HTRANS  in  2
- HBURST  in  3
- HSIZE  in  3
- HWRITE  in  1
- HREADY  in  1  bus-level ready
- HRESP  in  1
- clr  in  1  synchronous clear of sticky, count, first_addr
- viol_valid  out  1  pulse: at least one enabled check fired
- viol_vec  out  8  checks fired this report cycle
- viol_sticky  out  8  OR of all viol_vec since reset/clr
- viol_count  out  CNT_WIDTH  number of viol_valid pulses, saturating
- first_addr  out  ADDR_WIDTH  HADDR sampled at the first violation since reset/clr

## Operation
- Transfer accepted: HREADY=1 and HTRANS in {NONSEQ, SEQ}. Burst FSM states: B_IDLE, B_FIXED (SINGLE/INCR4/8/16/WRAP4/8/16), B_UNDEF (INCR).
- Accepted NONSEQ: latch HBURST/HSIZE/HWRITE; beats_left = len-1 (SINGLE: 0); next_addr = incr/wrap of HADDR. Go to B_FIXED, or B_UNDEF for INCR. SINGLE returns to B_IDLE at the next accepted transfer or IDLE.
- Accepted SEQ: decrement beats_left (B_FIXED); update next_addr.
- B_FIXED with beats_left = 0 returns to B_IDLE on the next IDLE/NONSEQ. B_UNDEF ends on IDLE/NONSEQ.
- INCR address: next = addr + (1<<HSIZE), modulo 2^ADDR_WIDTH.
- WRAPn address: boundary B = n<<HSIZE; next = (addr & ~(B-1)) | ((addr + (1<<HSIZE)) & (B-1)).
- Response FSM states: R_OK, R_ERR1.
  - R_OK -> R_ERR1 on HRESP=1, HREADY=0.
  - R_ERR1 -> R_OK always.
- Checks (bit: rule), evaluated on the sampled edge:
  - 0 SEQ_NO_BURST: SEQ/BUSY while B_IDLE.
  - 1 CTRL_CHANGE: SEQ/BUSY with HBURST/HSIZE/HWRITE differing from the latched values.
  - 2 ADDR_SEQ: accepted SEQ with HADDR ≠ next_addr.
  - 3 EARLY_TERM: IDLE/NONSEQ with HREADY=1 in B_FIXED while beats_left > 0, unless an ERROR second cycle occurred at or since the last accepted beat.
  - 4 OVERRUN: SEQ in B_FIXED with beats_left = 0.
  - 5 WAIT_STABLE: previous edge had HREADY=0 and HTRANS in {NONSEQ, SEQ}; now HTRANS or HADDR differs. The only exemption is the ERROR-cancel to IDLE on the second ERROR cycle.
  - 6 ERR_RESP: in R_ERR1, not (HRESP=1, HREADY=1); or in R_OK, HRESP=1 with HREADY=1.
  - 7 ALIGN_SIZE: NONSEQ/SEQ with HSIZE > max, or HADDR[HSIZE-1:0] ≠ 0.
- Masked checks never set any output. After a violation, tracking continues using the observed values (the resync rule); there is no lock-up.

## Timing
- All outputs reset to 0; both FSMs reset to B_IDLE/R_OK; beats_left and next_addr reset to 0.
- Report latency: violation on edge k -> viol_valid/viol_vec high for the cycle after edge k, low otherwise. The counter and sticky flags update on the same edge k.
- Back-to-back violations produce consecutive pulses; each increments viol_count by 1, saturating at all-ones.
- clr with a simultaneous violation: the violation wins over the clear. Result: sticky = viol_vec, count = 1, first_addr = current HADDR.
- Reset mid-burst: asynchronous clear. The first post-reset SEQ flags check 0.

## Structure
- Package ahb_pkg holds:
  - htrans_e (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - hburst_e (SINGLE=0 .. INCR16=7)
  - VIOL_* bit-index constants
  - functions burst_len(hburst) and next_addr(addr, size, burst)
- Sub-module ahb_burst_tracker holds the burst FSM, beat counter and expected-address logic.
- The top level holds the response FSM, the checks and the reporting registers.

## Test plan
- WRAP4, word size, NONSEQ 0x38 then SEQ 0x3C, 0x30, 0x34 -> no violation; viol_count stays 0.
- INCR4 with the third beat at 0x108 instead of 0x104 -> viol_vec=8'h04 for one cycle; first_addr=0x108; count=1.
- INCR8 cut by NONSEQ after 3 beats -> bit 3. Repeat with a two-cycle ERROR before the NONSEQ -> no violation.
- HRESP=1, HREADY=0 followed by HRESP=0, HREADY=1 -> bit 6; sticky=8'h40.
- SEQ from idle plus HSIZE=3 with DATA_WIDTH=32 on the same edge -> viol_vec=8'h81; with CHECK_EN=8'h7F -> 8'h01 only.
- clr asserted on the cycle of a violation, with count previously 5 -> count=1. Then 2^CNT_WIDTH+3 violations -> count saturates at all-ones.

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_pkg: AHB encodings, checker bit indices and burst address helpers.
// Revision: 1.0
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam int unsigned AW_MAX     = 64;
  localparam int unsigned NUM_CHECKS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_FIXED = 2'd1,
    B_UNDEF = 2'd2
  } bstate_e;

  typedef enum logic [0:0] {
    R_OK   = 1'b0,
    R_ERR1 = 1'b1
  } rstate_e;

  localparam int unsigned VIOL_SEQ_NO_BURST = 0;
  localparam int unsigned VIOL_CTRL_CHANGE  = 1;
  localparam int unsigned VIOL_ADDR_SEQ     = 2;
  localparam int unsigned VIOL_EARLY_TERM   = 3;
  localparam int unsigned VIOL_OVERRUN      = 4;
  localparam int unsigned VIOL_WAIT_STABLE  = 5;
  localparam int unsigned VIOL_ERR_RESP     = 6;
  localparam int unsigned VIOL_ALIGN_SIZE   = 7;

  // INCR has no defined length; it reports 1 so the beat counter stays at 0.
  function automatic logic [4:0] burst_len(input hburst_e hburst);
    case (hburst)
      WRAP4, INCR4:   burst_len = 5'd4;
      WRAP8, INCR8:   burst_len = 5'd8;
      WRAP16, INCR16: burst_len = 5'd16;
      default:        burst_len = 5'd1;
    endcase
  endfunction

  function automatic logic [AW_MAX-1:0] next_addr(input logic [AW_MAX-1:0] addr,
                                                  input logic [2:0]        size,
                                                  input hburst_e           burst);
    logic [AW_MAX-1:0] inc;
    logic [AW_MAX-1:0] sum;
    logic [AW_MAX-1:0] bnd;
    inc = AW_MAX'(1) << size;
    sum = addr + inc;
    case (burst)
      WRAP4:   bnd = inc << 2;
      WRAP8:   bnd = inc << 3;
      WRAP16:  bnd = inc << 4;
      default: bnd = '0;
    endcase
    if (bnd == '0) begin
      next_addr = sum;
    end else begin
      next_addr = (addr & ~(bnd - AW_MAX'(1))) | (sum & (bnd - AW_MAX'(1)));
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_burst_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_burst_tracker: burst FSM, remaining-beat counter and expected next address.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ahb_burst_tracker
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            htrans_i,
  input  logic                  hready_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [2:0]            hburst_i,
  input  logic [2:0]            hsize_i,
  input  logic                  hwrite_i,
  output logic                  in_idle_o,
  output logic                  in_fixed_o,
  output logic                  last_beat_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic [2:0]            burst_o,
  output logic [2:0]            size_o,
  output logic                  write_o
);

  bstate_e               state_q, state_d;
  logic [3:0]            beats_q, beats_d;
  logic [ADDR_WIDTH-1:0] naddr_q, naddr_d;
  hburst_e               burst_q, burst_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;

  htrans_e           w_trans;
  hburst_e           w_burst;
  logic [AW_MAX-1:0] w_nxt_ns_full;
  logic [AW_MAX-1:0] w_nxt_sq_full;

  assign w_trans       = htrans_e'(htrans_i);
  assign w_burst       = hburst_e'(hburst_i);
  assign w_nxt_ns_full = next_addr(AW_MAX'(haddr_i), hsize_i, w_burst);
  // SEQ beats follow the burst in progress but resync to the observed address.
  assign w_nxt_sq_full = next_addr(AW_MAX'(haddr_i), size_q, burst_q);

  if (ADDR_WIDTH < AW_MAX) begin : g_hi_unused
    logic w_unused_hi;
    assign w_unused_hi = ^{w_nxt_ns_full[AW_MAX-1:ADDR_WIDTH],
                           w_nxt_sq_full[AW_MAX-1:ADDR_WIDTH]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= B_IDLE;
      beats_q <= '0;
      naddr_q <= '0;
      burst_q <= SINGLE;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      naddr_q <= naddr_d;
      burst_q <= burst_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    naddr_d = naddr_q;
    burst_d = burst_q;
    size_d  = size_q;
    write_d = write_q;
    if (hready_i) begin
      case (w_trans)
        NONSEQ: begin
          state_d = (w_burst == INCR) ? B_UNDEF : B_FIXED;
          beats_d = 4'(burst_len(w_burst) - 5'd1);
          naddr_d = w_nxt_ns_full[ADDR_WIDTH-1:0];
          burst_d = w_burst;
          size_d  = hsize_i;
          write_d = hwrite_i;
        end
        SEQ: begin
          if (beats_q != '0) beats_d = beats_q - 4'd1;
          naddr_d = w_nxt_sq_full[ADDR_WIDTH-1:0];
        end
        IDLE:    state_d = B_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_idle_o   = (state_q == B_IDLE);
    in_fixed_o  = (state_q == B_FIXED);
    last_beat_o = (beats_q == '0);
    next_addr_o = naddr_q;
    burst_o     = burst_q;
    size_o      = size_q;
    write_o     = write_q;
  end

endmodule
`default_nettype wire

// File: rtl/ahb_protocol_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_protocol_checker: passive AHB rule checker with pulse, sticky and count reporting.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ahb_protocol_checker
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [7:0]  CHECK_EN   = 8'hFF
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HBURST,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic                  clr,
  output logic                  viol_valid,
  output logic [7:0]            viol_vec,
  output logic [7:0]            viol_sticky,
  output logic [CNT_WIDTH-1:0]  viol_count,
  output logic [ADDR_WIDTH-1:0] first_addr
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  logic                  w_b_idle, w_b_fixed, w_last_beat, w_l_write;
  logic [ADDR_WIDTH-1:0] w_exp_addr;
  logic [2:0]            w_l_burst, w_l_size;

  ahb_burst_tracker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_tracker (
    .clk_i       (HCLK),
    .rst_ni      (HRESETn),
    .htrans_i    (HTRANS),
    .hready_i    (HREADY),
    .haddr_i     (HADDR),
    .hburst_i    (HBURST),
    .hsize_i     (HSIZE),
    .hwrite_i    (HWRITE),
    .in_idle_o   (w_b_idle),
    .in_fixed_o  (w_b_fixed),
    .last_beat_o (w_last_beat),
    .next_addr_o (w_exp_addr),
    .burst_o     (w_l_burst),
    .size_o      (w_l_size),
    .write_o     (w_l_write)
  );

  rstate_e               resp_q, resp_d;
  logic                  err_seen_q, err_seen_d;
  logic                  pend_q;
  logic [1:0]            pend_trans_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic                  valid_q;
  logic [7:0]            vec_q;
  logic [7:0]            sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;

  htrans_e               w_trans;
  logic                  w_active, w_seq_busy, w_acc, w_err2, w_resp_bad, w_any;
  logic [ADDR_WIDTH-1:0] w_align_mask;
  logic [7:0]            w_raw, w_vec;

  assign w_trans      = htrans_e'(HTRANS);
  assign w_active     = (w_trans == NONSEQ) || (w_trans == SEQ);
  assign w_seq_busy   = (w_trans == SEQ) || (w_trans == BUSY);
  assign w_acc        = HREADY && w_active;
  assign w_align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) resp_q <= R_OK;
    else          resp_q <= resp_d;
  end

  always_comb begin
    resp_d = resp_q;
    case (resp_q)
      R_OK:    if (HRESP && !HREADY) resp_d = R_ERR1;
      default: resp_d = R_OK;
    endcase
  end

  always_comb begin
    w_err2     = (resp_q == R_ERR1) && HRESP && HREADY;
    w_resp_bad = (resp_q == R_ERR1) ? !(HRESP && HREADY) : (HRESP && HREADY);
  end

  // An ERROR completion excuses early termination until the next accepted beat.
  assign err_seen_d = w_err2 ? 1'b1 : (w_acc ? 1'b0 : err_seen_q);

  always_comb begin
    w_raw = '0;
    w_raw[VIOL_SEQ_NO_BURST] = w_seq_busy && w_b_idle;
    w_raw[VIOL_CTRL_CHANGE]  = w_seq_busy && !w_b_idle &&
                               ((HBURST != w_l_burst) || (HSIZE != w_l_size) ||
                                (HWRITE != w_l_write));
    w_raw[VIOL_ADDR_SEQ]     = HREADY && (w_trans == SEQ) && !w_b_idle &&
                               (HADDR != w_exp_addr);
    w_raw[VIOL_EARLY_TERM]   = HREADY && ((w_trans == IDLE) || (w_trans == NONSEQ)) &&
                               w_b_fixed && !w_last_beat && !(err_seen_q || w_err2);
    w_raw[VIOL_OVERRUN]      = (w_trans == SEQ) && w_b_fixed && w_last_beat;
    w_raw[VIOL_WAIT_STABLE]  = pend_q && ((HTRANS != pend_trans_q) || (HADDR != pend_addr_q)) &&
                               !(w_err2 && (w_trans == IDLE));
    w_raw[VIOL_ERR_RESP]     = w_resp_bad;
    w_raw[VIOL_ALIGN_SIZE]   = w_active && ((HSIZE > MAX_SIZE) || ((HADDR & w_align_mask) != '0));
  end

  assign w_vec = w_raw & CHECK_EN;
  assign w_any = |w_vec;

  // A violation on the clr edge still records itself against the cleared state.
  always_comb begin
    sticky_d = clr ? '0 : sticky_q;
    count_d  = clr ? '0 : count_q;
    first_d  = clr ? '0 : first_q;
    if (w_any) begin
      if (count_d == '0) first_d = HADDR;
      sticky_d = sticky_d | w_vec;
      if (count_d != '1) count_d = count_d + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_seen_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_trans_q <= '0;
      pend_addr_q  <= '0;
      valid_q      <= 1'b0;
      vec_q        <= '0;
      sticky_q     <= '0;
      count_q      <= '0;
      first_q      <= '0;
    end else begin
      err_seen_q   <= err_seen_d;
      pend_q       <= !HREADY && w_active;
      pend_trans_q <= HTRANS;
      pend_addr_q  <= HADDR;
      valid_q      <= w_any;
      vec_q        <= w_vec;
      sticky_q     <= sticky_d;
      count_q      <= count_d;
      first_q      <= first_d;
    end
  end

  assign viol_valid  = valid_q;
  assign viol_vec    = vec_q;
  assign viol_sticky = sticky_q;
  assign viol_count  = count_q;
  assign first_addr  = first_q;

endmodule
`default_nettype wire
